proc_mem_ctrl: RTL and testbench

- Memory subsystem directly downstream of the processor core.
- Consumes the core's command/address/write-data bus and returns instruction words, load data, a ready handshake, a start-up ready flag and an error code.
- Holds a unified word-addressed single-port RAM with a configurable access latency.
- RAM is zero-cleared and then loaded by a host port before the core is released.

---
 rtl/proc_mem_ctrl_if.sv | 35 +++
 rtl/proc_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_proc_mem_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_ctrl_if.sv
// rtl/proc_mem_ctrl_if.sv - core-to-memory command/response bus
//
// Purpose: bundles the processor core's request signals and the memory
// subsystem's response signals into one bus.
// Signals:
//   command    [2:0]  core -> mem  0 none, 1 fetch, 2 read+fetch, 3 write+fetch, 4 fetch
//   pc         [31:0] core -> mem  instruction byte address
//   data_addr  [31:0] core -> mem  data byte address
//   data_wdata [31:0] core -> mem  write data
//   data_wstrb [3:0]  core -> mem  byte enables for writes
//   ready             mem -> core  idle with results valid
//   inst_rdata [31:0] mem -> core  fetched instruction word
//   data_rdata [31:0] mem -> core  loaded data word
//   error      [1:0]  mem -> core  0 ok, 1 misaligned pc, 2 out of range
interface proc_mem_ctrl_if;
  logic [2:0]  command;
  logic [31:0] pc;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        ready;
  logic [31:0] inst_rdata;
  logic [31:0] data_rdata;
  logic [1:0]  error;

  modport master (
    output command, pc, data_addr, data_wdata, data_wstrb,
    input  ready, inst_rdata, data_rdata, error
  );

  modport slave (
    input  command, pc, data_addr, data_wdata, data_wstrb,
    output ready, inst_rdata, data_rdata, error
  );
endinterface

// File: rtl/proc_mem_ctrl.sv
// rtl/proc_mem_ctrl.sv - unified instruction/data memory controller for the core
//
// Purpose: word-addressed single-port RAM behind the core bus. After reset the
// RAM is zero-cleared (INIT), filled by a host (LOAD), then serves core
// commands with LATENCY cycles per access phase.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   bus                core bus (slave side of proc_mem_ctrl_if)
//   mem_start_ready    high once host loading has finished
//   load_valid         host word write strobe (LOAD only)
//   load_addr          host word index (taken modulo MEM_WORDS)
//   load_data          host write data
//   load_done          ends LOAD
module proc_mem_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  proc_mem_ctrl_if.slave  bus,
  output logic            mem_start_ready,
  input  logic            load_valid,
  input  logic [31:0]     load_addr,
  input  logic [31:0]     load_data,
  input  logic            load_done
);
  localparam int              AW         = $clog2(MEM_WORDS);
  localparam logic [31:0]     BYTE_LIMIT = 32'(4 * MEM_WORDS);
  localparam logic [AW-1:0]   LAST_WORD  = AW'(MEM_WORDS - 1);
  localparam logic [3:0]      LAT_LAST   = 4'(LATENCY - 1);

  typedef enum logic [2:0] {S_INIT, S_LOAD, S_IDLE, S_DATA, S_FETCH, S_ERR} state_t;
  state_t state, state_n;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] clr_cnt;
  logic [3:0]    lat_cnt;
  logic [AW-1:0] pc_idx, data_idx;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          write_q;
  logic [31:0]   inst_q, rdata_q;
  logic [1:0]    error_q;

  logic          lat_done, cmd_data, pc_misaligned, pc_oor, data_oor;
  logic          accept, set_err;
  logic [1:0]    err_code;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wd;
  logic [3:0]    mem_be;

  assign lat_done      = (lat_cnt == LAT_LAST);
  assign cmd_data      = (bus.command == 3'd2) || (bus.command == 3'd3);
  assign pc_misaligned = (bus.pc[1:0] != 2'b00);
  // Range checks use the full 32-bit address; truncation to a word index
  // happens only when the request is latched.
  assign pc_oor        = (bus.pc >= BYTE_LIMIT);
  assign data_oor      = cmd_data && (bus.data_addr >= BYTE_LIMIT);

  assign bus.ready      = (state == S_IDLE);
  assign bus.inst_rdata = inst_q;
  assign bus.data_rdata = rdata_q;
  assign bus.error      = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    set_err  = 1'b0;
    err_code = 2'd0;
    mem_we   = 1'b0;
    mem_idx  = '0;
    mem_wd   = '0;
    mem_be   = 4'h0;
    case (state)
      S_INIT: begin
        mem_we  = 1'b1;
        mem_idx = clr_cnt;
        mem_be  = 4'hF;
        if (clr_cnt == LAST_WORD) state_n = S_LOAD;
      end
      S_LOAD: begin
        // The write is issued even when load_done arrives in the same cycle.
        if (load_valid) begin
          mem_we  = 1'b1;
          mem_idx = AW'(load_addr);
          mem_wd  = load_data;
          mem_be  = 4'hF;
        end
        if (load_done) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (bus.command != 3'd0) begin
          accept = 1'b1;
          if (pc_misaligned) begin
            set_err  = 1'b1;
            err_code = 2'd1;
            state_n  = S_ERR;
          end else if (pc_oor || data_oor) begin
            set_err  = 1'b1;
            err_code = 2'd2;
            state_n  = S_ERR;
          end else begin
            state_n = cmd_data ? S_DATA : S_FETCH;
          end
        end
      end
      S_DATA: begin
        if (lat_done) begin
          if (write_q) begin
            mem_we  = 1'b1;
            mem_idx = data_idx;
            mem_wd  = wdata_q;
            mem_be  = wstrb_q;
          end
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (lat_done) state_n = S_IDLE;
      end
      S_ERR: begin
        state_n = S_ERR;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt         <= '0;
      lat_cnt         <= 4'd0;
      pc_idx          <= '0;
      data_idx        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= 4'h0;
      write_q         <= 1'b0;
      inst_q          <= '0;
      rdata_q         <= '0;
      error_q         <= 2'd0;
      mem_start_ready <= 1'b0;
    end else begin
      if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_LOAD && load_done) mem_start_ready <= 1'b1;
      // Each access phase counts from zero on entry.
      if (state_n != state) lat_cnt <= 4'd0;
      else if (state == S_DATA || state == S_FETCH) lat_cnt <= lat_cnt + 4'd1;
      if (accept) begin
        pc_idx   <= AW'(bus.pc >> 2);
        data_idx <= AW'(bus.data_addr >> 2);
        wdata_q  <= bus.data_wdata;
        wstrb_q  <= bus.data_wstrb;
        write_q  <= (bus.command == 3'd3);
      end
      if (set_err) error_q <= err_code;
      if (state == S_DATA && lat_done && !write_q) rdata_q <= mem[data_idx];
      if (state == S_FETCH && lat_done) inst_q <= mem[pc_idx];
    end
  end

  // RAM contents are not reset; INIT clears them after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_proc_mem_ctrl.sv
// tb/tb_proc_mem_ctrl.sv - scoreboard bench for proc_mem_ctrl
module tb_proc_mem_ctrl;
  localparam int MW  = 16;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msr;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [MW];
  logic [31:0] model_data;

  always #5 clk = ~clk;

  proc_mem_ctrl_if bus_if ();

  proc_mem_ctrl #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .mem_start_ready (msr),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_load();
    logic [31:0] addrs [5];
    logic [31:0] datas [5];
    logic [31:0] a;
    addrs = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd21};
    datas = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    rst_n = 1'b0;
    bus_if.command = 3'd0;
    tick();
    tick();
    check("rst_ready", 32'(bus_if.ready), 32'd0);
    check("rst_msr", 32'(msr), 32'd0);
    check("rst_error", 32'(bus_if.error), 32'd0);
    check("rst_inst", bus_if.inst_rdata, 32'd0);
    check("rst_data", bus_if.data_rdata, 32'd0);
    for (int i = 0; i < MW; i++) model_mem[i] = 32'd0;
    model_data = 32'd0;
    sb_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < MW; i++) begin
      tick();
      check("init_msr", 32'(msr), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_addr  = addrs[i];
      load_data  = datas[i];
      load_done  = (i == 4);
      a = addrs[i] % MW;
      model_mem[a[3:0]] = datas[i];
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    check("load_msr", 32'(msr), 32'd1);
    check("load_ready", 32'(bus_if.ready), 32'd1);
  endtask

  task automatic drive_cmd(input logic [2:0] cmd, input logic [31:0] pc, input logic [31:0] daddr,
                           input logic [31:0] wd, input logic [3:0] ws);
    bus_if.command    = cmd;
    bus_if.pc         = pc;
    bus_if.data_addr  = daddr;
    bus_if.data_wdata = wd;
    bus_if.data_wstrb = ws;
  endtask

  task automatic issue(input string tag, input logic [2:0] cmd, input logic [31:0] pc,
                       input logic [31:0] daddr, input logic [31:0] wd, input logic [3:0] ws);
    exp_t        e;
    logic [31:0] didx, pidx;
    logic        is_data;
    is_data = (cmd == 3'd2) || (cmd == 3'd3);
    didx = daddr >> 2;
    pidx = pc >> 2;
    if (cmd == 3'd3) begin
      for (int i = 0; i < 4; i++)
        if (ws[i]) model_mem[didx[3:0]][8*i +: 8] = wd[8*i +: 8];
    end
    if (cmd == 3'd2) model_data = model_mem[didx[3:0]];
    e.tag  = tag;
    e.inst = model_mem[pidx[3:0]];
    e.data = model_data;
    e.lat  = is_data ? 2 * LAT : LAT;
    sb_q.push_back(e);
    drive_cmd(cmd, pc, daddr, wd, ws);
    tick();
    bus_if.command = 3'd0;
    check({tag, "_busy"}, 32'(bus_if.ready), 32'd0);
  endtask

  task automatic collect(input int n0);
    exp_t e;
    int   n;
    n = n0;
    while (bus_if.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_lat"}, 32'(n), 32'(e.lat));
      check({e.tag, "_inst"}, bus_if.inst_rdata, e.inst);
      check({e.tag, "_data"}, bus_if.data_rdata, e.data);
      check({e.tag, "_err"}, 32'(bus_if.error), 32'd0);
    end
  endtask

  task automatic issue_err(input string tag, input logic [2:0] cmd, input logic [31:0] pc,
                           input logic [31:0] daddr, input logic [1:0] exp_err);
    logic seen;
    seen = 1'b0;
    drive_cmd(cmd, pc, daddr, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus_if.command = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.ready === 1'b1) seen = 1'b1;
      tick();
    end
    check({tag, "_ready"}, 32'(seen), 32'd0);
    check({tag, "_code"}, 32'(bus_if.error), 32'(exp_err));
    check({tag, "_data"}, bus_if.data_rdata, model_data);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_done  = 1'b0;
    drive_cmd(3'd0, 32'd0, 32'd0, 32'd0, 4'h0);

    reset_and_load();

    tick();
    check("cmd0_ready", 32'(bus_if.ready), 32'd1);

    issue("fetch8", 3'd1, 32'd8, 32'd0, 32'd0, 4'h0);
    collect(0);
    issue("wr4", 3'd3, 32'd4, 32'd4, 32'hAABB_CCDD, 4'b0101);
    collect(0);
    check("wr4_merge", bus_if.inst_rdata, 32'h00BB_00DD);
    issue("rd4", 3'd2, 32'd0, 32'd4, 32'd0, 4'h0);
    collect(0);
    issue("cmd5", 3'd5, 32'd12, 32'h1000, 32'd0, 4'h0);
    collect(0);
    issue("cmd4", 3'd4, 32'd20, 32'hFFFF_FFF0, 32'd0, 4'h0);
    collect(0);

    // A second command pulsed while busy must be dropped.
    issue("busy1", 3'd1, 32'd0, 32'd0, 32'd0, 4'h0);
    drive_cmd(3'd3, 32'd8, 32'd0, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus_if.command = 3'd0;
    collect(1);
    issue("after_busy", 3'd2, 32'd8, 32'd0, 32'd0, 4'h0);
    collect(0);

    issue_err("oor_data", 3'd2, 32'd0, 32'h40, 2'd2);
    reset_and_load();
    issue_err("misalign", 3'd1, 32'd6, 32'd0, 2'd1);
    reset_and_load();
    issue_err("both", 3'd1, 32'h41, 32'd0, 2'd1);
    reset_and_load();
    issue_err("pc_oor", 3'd1, 32'h40, 32'd0, 2'd2);
    reset_and_load();

    // Reset in the middle of the DATA phase of a write.
    drive_cmd(3'd3, 32'd32, 32'd32, 32'hCAFE_F00D, 4'hF);
    tick();
    bus_if.command = 3'd0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus_if.ready), 32'd0);
    check("midrst_msr", 32'(msr), 32'd0);
    reset_and_load();
    issue("midrst_word", 3'd2, 32'd32, 32'd32, 32'd0, 4'h0);
    collect(0);
    check("midrst_zero", bus_if.data_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
